// File: rtl/brisc_pkg.sv
// ============================================================================
// Module      : brisc_pkg
// Description : Shared constants and types for the brisc pipeline, including
//               the skid-buffer handshake state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package brisc_pkg;

  // Architectural datapath width
  localparam int XLEN = 32;

  // Occupancy states of the two-entry skid register slice
  typedef enum logic [1:0] {
    SKID_EMPTY,
    SKID_BUSY,
    SKID_FULL
  } skid_state_e;

endpackage : brisc_pkg

`default_nettype wire

// File: rtl/pipe_skid_ctrl.sv
// ============================================================================
// Module      : pipe_skid_ctrl
// Description : Occupancy state machine for the skid register slice. Produces
//               registered in_ready/out_valid and the load enables used by the
//               datapath registers in the parent.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_skid_ctrl
  import brisc_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic flush,
  input  logic in_valid,
  input  logic out_ready,
  output logic in_ready,
  output logic out_valid,
  output logic load_main_in,
  output logic load_main_skid,
  output logic load_skid
);

  skid_state_e state;
  skid_state_e state_nxt;
  logic        in_fire;
  logic        out_fire;

  // Handshakes only use flop outputs on our side, so no ready->ready path exists
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Next state and register load enables; flush overrides every handshake
  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_nxt = SKID_EMPTY;
    end else begin
      case (state)
        SKID_EMPTY: begin
          if (in_fire) begin
            load_main_in = 1'b1;
            state_nxt    = SKID_BUSY;
          end
        end
        SKID_BUSY: begin
          if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (in_fire) begin
            load_skid = 1'b1;
            state_nxt = SKID_FULL;
          end else if (out_fire) begin
            state_nxt = SKID_EMPTY;
          end
        end
        SKID_FULL: begin
          if (out_fire) begin
            load_main_skid = 1'b1;
            state_nxt      = SKID_BUSY;
          end
        end
        default: begin
          state_nxt = SKID_EMPTY;
        end
      endcase
    end
  end

  // State register with handshake flags registered from the next state;
  // in_ready stays low in reset and rises on the first edge afterwards
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= SKID_EMPTY;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt != SKID_FULL);
      out_valid <= (state_nxt != SKID_EMPTY);
    end
  end

endmodule : pipe_skid_ctrl

`default_nettype wire

// File: rtl/pipe_skid_buf.sv
// ============================================================================
// Module      : pipe_skid_buf
// Description : Two-entry valid/ready register slice with a one-beat skid
//               register and a saturating consumer-stall counter. All outputs
//               are registered.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_skid_buf
  import brisc_pkg::*;
#(
  parameter int   WIDTH       = XLEN,
  parameter logic RESET_VALUE = 1'b0,
  parameter int   CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [WIDTH-1:0] skid_data;
  logic             load_main_in;
  logic             load_main_skid;
  logic             load_skid;

  pipe_skid_ctrl u_ctrl (
    .clk            (clk),
    .reset_n        (reset_n),
    .flush          (flush),
    .in_valid       (in_valid),
    .out_ready      (out_ready),
    .in_ready       (in_ready),
    .out_valid      (out_valid),
    .load_main_in   (load_main_in),
    .load_main_skid (load_main_skid),
    .load_skid      (load_skid)
  );

  // Main register drives out_data; refilled from input or from the skid entry
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data <= {WIDTH{RESET_VALUE}};
    end else if (load_main_in) begin
      out_data <= in_data;
    end else if (load_main_skid) begin
      out_data <= skid_data;
    end
  end

  // Skid register captures the beat that arrives while the consumer stalls
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      skid_data <= {WIDTH{RESET_VALUE}};
    end else if (load_skid) begin
      skid_data <= in_data;
    end
  end

  // Saturating count of cycles where a valid beat waits on the consumer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if (flush) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule : pipe_skid_buf

`default_nettype wire

// File: tb/tb_pipe_skid_buf.sv
// ============================================================================
// Module      : tb_pipe_skid_buf
// Description : Self-checking bench for pipe_skid_buf. A queue of at most two
//               beats models the slice; directed scenarios are followed by a
//               randomized handshake run.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_skid_buf;
  import brisc_pkg::*;

  localparam int W     = XLEN;
  localparam int CW    = 4;
  localparam int SMAX  = (1 << CW) - 1;

  logic          clk;
  logic          reset_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [CW-1:0] stall_cnt;

  pipe_skid_buf #(
    .WIDTH       (W),
    .RESET_VALUE (1'b0),
    .CNT_W       (CW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: ordered beats held by the slice, registered ready flag,
  // and the saturating stall count
  logic [W-1:0] q[$];
  bit           ready_m;
  int           stall_m;
  bit           last_fire;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".out_valid"}, W'(out_valid), W'(q.size() > 0));
    chk({tag, ".in_ready"},  W'(in_ready),  W'(ready_m));
    chk({tag, ".stall_cnt"}, W'(stall_cnt), W'(stall_m));
    if (q.size() > 0) chk({tag, ".out_data"}, out_data, q[0]);
  endtask

  task automatic model_reset();
    q.delete();
    ready_m = 1'b0;
    stall_m = 0;
  endtask

  // One clock cycle: drive at negedge, advance model at posedge, check after it
  task automatic step(input bit iv, input logic [W-1:0] id, input bit ordy,
                      input bit fl, input string tag);
    bit inf;
    bit outf;
    @(negedge clk);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    inf  = iv && ready_m && !fl;
    outf = (q.size() > 0) && ordy && !fl;
    if (fl) begin
      q.delete();
      stall_m = 0;
    end else begin
      if ((q.size() > 0) && !ordy && (stall_m < SMAX)) stall_m++;
      if (outf) void'(q.pop_front());
      if (inf) q.push_back(id);
    end
    ready_m   = (q.size() < 2);
    last_fire = inf;
    #1;
    compare_all(tag);
  endtask

  initial begin
    bit           pend_v;
    logic [W-1:0] pend_d;
    bit           ordy;
    bit           fl;

    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    model_reset();

    // Reset held three cycles
    repeat (3) @(posedge clk);
    #1;
    chk("rst.out_valid", W'(out_valid), '0);
    chk("rst.in_ready",  W'(in_ready),  '0);
    chk("rst.out_data",  out_data,      '0);
    chk("rst.stall_cnt", W'(stall_cnt), '0);
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b0, '0, 1'b1, 1'b0, "idle");
    step(1'b0, '0, 1'b1, 1'b0, "idle2");

    // Full-rate streaming
    step(1'b1, 32'h11, 1'b1, 1'b0, "stream11");
    step(1'b1, 32'h22, 1'b1, 1'b0, "stream22");
    step(1'b1, 32'h33, 1'b1, 1'b0, "stream33");
    step(1'b0, '0,     1'b1, 1'b0, "stream_end");

    // Skid capture under consumer stall
    step(1'b1, 32'hA0, 1'b1, 1'b0, "skidA0");
    step(1'b1, 32'hB0, 1'b0, 1'b0, "skidB0");
    chk("skid.in_ready_low", W'(in_ready), '0);
    chk("skid.stall1", W'(stall_cnt), W'(1));
    step(1'b0, '0, 1'b0, 1'b0, "skid_hold1");
    step(1'b0, '0, 1'b0, 1'b0, "skid_hold2");
    chk("skid.stall3", W'(stall_cnt), W'(3));
    chk("skid.main_held", out_data, 32'hA0);
    step(1'b0, '0, 1'b1, 1'b0, "drainA0");
    chk("drain.in_ready_back", W'(in_ready), W'(1));
    chk("drain.skid_to_main", out_data, 32'hB0);
    step(1'b0, '0, 1'b1, 1'b0, "drainB0");

    // Flush while full, with a beat offered in the same cycle
    step(1'b1, 32'h01, 1'b0, 1'b0, "fill1");
    step(1'b1, 32'h02, 1'b0, 1'b0, "fill2");
    step(1'b1, 32'hCC, 1'b0, 1'b1, "flush");
    chk("flush.out_valid", W'(out_valid), '0);
    chk("flush.in_ready",  W'(in_ready),  W'(1));
    chk("flush.stall_cnt", W'(stall_cnt), '0);
    step(1'b0, '0, 1'b1, 1'b0, "post_flush1");
    step(1'b0, '0, 1'b1, 1'b0, "post_flush2");

    // Stall counter saturation
    step(1'b1, 32'h77, 1'b0, 1'b0, "sat_load");
    repeat (20) step(1'b0, '0, 1'b0, 1'b0, "sat_hold");
    chk("sat.stall15", W'(stall_cnt), W'(15));
    step(1'b0, '0, 1'b1, 1'b0, "sat_drain");

    // Randomized traffic; the producer holds its beat until it is accepted
    pend_v = 1'b0;
    pend_d = '0;
    for (int i = 0; i < 400; i++) begin
      if (!pend_v && ($urandom_range(0, 2) != 0)) begin
        pend_v = 1'b1;
        pend_d = $urandom;
      end
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 31) == 0);
      step(pend_v, pend_d, ordy, fl, "rand");
      if (last_fire || fl) pend_v = 1'b0;
    end
    step(1'b0, '0, 1'b1, 1'b0, "rand_drain1");
    step(1'b0, '0, 1'b1, 1'b0, "rand_drain2");

    // Asynchronous reset between edges while holding a beat
    step(1'b1, 32'h55, 1'b0, 1'b0, "busy55");
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst.out_valid", W'(out_valid), '0);
    chk("arst.out_data",  out_data,      '0);
    chk("arst.stall_cnt", W'(stall_cnt), '0);
    model_reset();
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b0, '0, 1'b1, 1'b0, "arst_release");
    chk("arst.out_data_after", out_data, '0);
    step(1'b0, '0, 1'b1, 1'b0, "arst_idle");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_pipe_skid_buf

`default_nettype wire

// File: doc/pipe_skid_buf.md
# pipe_skid_buf

Two-entry valid/ready register slice placed directly downstream of an enable/reset pipeline register bank, converting its enable-based stall scheme into a registered backpressure handshake toward the next stage. It accepts one beat per cycle at full throughput, absorbs one in-flight beat when the consumer stalls, and keeps every output registered so no combinational path runs from `out_ready` to `in_ready`. A saturating stall counter exposes consumer backpressure for performance debug.

## Interface
- `WIDTH`, default `XLEN`: payload width in bits.
- `RESET_VALUE`, default `1'b0`: bit replicated into the data registers on reset.
- `CNT_W`, default 16: width of the stall counter.

- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous, active-high; discards all held beats.
- `in_valid`  in  1  upstream beat present.
- `in_ready`  out  1  registered; slice can accept a beat this cycle.
- `in_data`  in  WIDTH  upstream payload.
- `out_valid`  out  1  registered; `out_data` holds a valid beat.
- `out_ready`  in  1  downstream accepts the beat this cycle.
- `out_data`  out  WIDTH  registered payload, sourced from the main register only.
- `stall_cnt`  out  CNT_W  cycles with `out_valid && !out_ready`; saturates at all-ones.

## Operation
- Input fire = `in_valid && in_ready`. Output fire = `out_valid && out_ready`.
- Storage: main register (drives `out_data`) and skid register.
- States:
  - EMPTY: `out_valid=0`, `in_ready=1`.
  - BUSY: main register full, `out_valid=1`, `in_ready=1`.
  - FULL: main and skid registers full, `out_valid=1`, `in_ready=0`.
- EMPTY: on input fire, main is loaded from `in_data` and the state goes to BUSY. Otherwise it stays EMPTY.
- BUSY:
  - Input and output fire together: main is loaded from `in_data`, state stays BUSY.
  - Input fire only: skid is loaded from `in_data`, state goes to FULL.
  - Output fire only: state goes to EMPTY.
  - Neither: hold.
- FULL: on output fire, main is loaded from skid and the state goes to BUSY. Otherwise hold. No input can fire in FULL.
- Flush has priority over all handshake activity. Next state is EMPTY and any input beat in the same cycle is dropped. Data registers are not cleared. `stall_cnt` is cleared.
- `stall_cnt` increments by 1 each cycle with `out_valid && !out_ready` and no flush. It holds at `{CNT_W{1'b1}}`.
- Beat order is strictly preserved. No beat is duplicated or lost except by flush.

## Timing
- Reset (`reset_n` low, asynchronous) sets:
  - state EMPTY, `out_valid=0`, `in_ready=0`;
  - `out_data` and skid register to `{WIDTH{RESET_VALUE}}`;
  - `stall_cnt=0`.
- `in_ready` rises to 1 on the first `clk` edge after `reset_n` deasserts.
- Reset asserted mid-operation drops all held beats immediately, without waiting for a clock edge.
- Latency: a beat accepted at edge N appears on `out_data` with `out_valid=1` after edge N, i.e. one cycle.
- Throughput: one beat per cycle in steady state with `out_ready=1`.
- `in_ready` deasserts the cycle after a stalled acceptance (FULL). It reasserts the cycle after the output fire that drains the skid register.
- `in_ready` and `out_valid` are flop outputs. They have no combinational dependence on `in_valid`, `out_ready` or `flush`.
- The upstream producer must hold `in_valid`/`in_data` stable until fire.
- `out_valid`/`out_data` are held stable by this block until output fire or flush.

## Structure
- `brisc_pkg` gains `typedef enum logic [1:0] {SKID_EMPTY, SKID_BUSY, SKID_FULL} skid_state_e`.
- `WIDTH` defaults from the existing `XLEN` constant.
- One sub-module: `pipe_skid_ctrl`. It contains the state register, next-state logic, and the load enables for the main and skid registers.
- Datapath registers and `stall_cnt` live in `pipe_skid_buf`.

## Test plan
- Reset then idle: hold `reset_n=0` 3 cycles, release. Expect `out_valid=0`, `out_data=0`, `stall_cnt=0`, and `in_ready=1` from the first edge after release.
- Streaming: `out_ready=1`, drive 0x11,0x22,0x33 on consecutive cycles. Expect `out_data` 0x11,0x22,0x33 on the next three cycles with `in_ready` constantly 1.
- Skid capture:
  - Stimulus: send 0xA0 then 0xB0 back-to-back, with `out_ready=0` from the second cycle.
  - Expect state FULL, `in_ready=0`, `out_data=0xA0` held, and `stall_cnt` counting 1,2,3.
  - Then raise `out_ready`. Expect 0xA0 then 0xB0 out, and `in_ready=1` one cycle after the first output fire.
- Flush while FULL with `in_valid=1` carrying 0xCC. Expect next cycle `out_valid=0`, `in_ready=1`, `stall_cnt=0`, and 0xCC never emitted.
- Stall counter saturation: `CNT_W=4`, one beat held with `out_ready=0` for 20 cycles. Expect `stall_cnt` stops at 15.
- Async reset mid-stream:
  - Stimulus: assert `reset_n=0` between edges while BUSY with 0x55.
  - Expect `out_valid=0` before the next edge.
  - After release, 0x55 never appears and `out_data=0`.
